utlb_lookup_sequencer: RTL

- Shares one unified TLB read port between the instruction-fetch requester (IMMU) and the load/store requester (DMMU).
- Arbitrates the two requesters, then scans the TLB one entry per cycle, applying the standard match rule (V, TS, TID/PID, EPN) and the SR/UR/SW/UW/SX/UX permission rule.
- Returns hit, matched index and exception code to the requester that was granted.
- Sits between the fetch/LSU translation front ends and the TLB array.

---
 rtl/mmu_pkg.sv | 40 ++++
 rtl/utlb_lookup_sequencer_if.sv | 34 +++
 rtl/utlb_entry_check.sv | 32 +++
 rtl/utlb_lookup_sequencer.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/mmu_pkg.sv
// Shared types and constants for the unified TLB lookup sequencer.
package mmu_pkg;

    localparam int unsigned EPN_W  = 20;
    localparam int unsigned PID_W  = 8;
    localparam int unsigned EXC_W  = 5;
    localparam int unsigned PERM_W = 6;

    // ISI/DSI match the core's interrupt vector numbering; TLB misses use the next free codes
    localparam logic [EXC_W-1:0] EXC_NONE = 5'd0;
    localparam logic [EXC_W-1:0] EXC_DSI  = 5'd2;
    localparam logic [EXC_W-1:0] EXC_ISI  = 5'd3;
    localparam logic [EXC_W-1:0] EXC_DTLB = 5'd13;
    localparam logic [EXC_W-1:0] EXC_ITLB = 5'd14;

    localparam int unsigned PERM_UX = 0;
    localparam int unsigned PERM_SX = 1;
    localparam int unsigned PERM_UW = 2;
    localparam int unsigned PERM_SW = 3;
    localparam int unsigned PERM_UR = 4;
    localparam int unsigned PERM_SR = 5;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    typedef struct packed {
        logic             is_d;
        logic             store;
        logic             pr;
        logic             as;
        logic [EPN_W-1:0] epn;
        logic [PID_W-1:0] pid0;
        logic [PID_W-1:0] pid1;
        logic [PID_W-1:0] pid2;
    } req_t;

endpackage

// File: rtl/utlb_lookup_sequencer_if.sv
// IMMU/DMMU request and response bundle for the TLB lookup sequencer.
interface utlb_lookup_sequencer_if #(
    parameter int unsigned IDX_W = 4
);
    import mmu_pkg::*;

    logic             I_Req;
    logic             I_AS;
    logic [EPN_W-1:0] I_EA_EPN;
    logic             D_Req;
    logic             D_AS;
    logic [EPN_W-1:0] D_EA_EPN;
    logic             D_Ins_Type;

    logic             I_Ack;
    logic             I_Hit;
    logic [IDX_W-1:0] I_Idx;
    logic [EXC_W-1:0] I_Exception;
    logic             D_Ack;
    logic             D_Hit;
    logic [IDX_W-1:0] D_Idx;
    logic [EXC_W-1:0] D_Exception;

    modport master (
        output I_Req, I_AS, I_EA_EPN, D_Req, D_AS, D_EA_EPN, D_Ins_Type,
        input  I_Ack, I_Hit, I_Idx, I_Exception, D_Ack, D_Hit, D_Idx, D_Exception
    );

    modport slave (
        input  I_Req, I_AS, I_EA_EPN, D_Req, D_AS, D_EA_EPN, D_Ins_Type,
        output I_Ack, I_Hit, I_Idx, I_Exception, D_Ack, D_Hit, D_Idx, D_Exception
    );

endinterface

// File: rtl/utlb_entry_check.sv
// Combinational match and permission check of one TLB entry against the latched request.
module utlb_entry_check
    import mmu_pkg::*;
(
    input  req_t              req,
    input  logic              entry_v,
    input  logic              entry_ts,
    input  logic [PID_W-1:0]  entry_tid,
    input  logic [EPN_W-1:0]  entry_epn,
    input  logic [PERM_W-1:0] entry_permis,
    output logic              match,
    output logic              perm_ok
);

    logic tid_ok;

    assign tid_ok = (entry_tid == '0) || (entry_tid == req.pid0) ||
                    (entry_tid == req.pid1) || (entry_tid == req.pid2);

    assign match = entry_v && (entry_ts == req.as) && (entry_epn == req.epn) && tid_ok;

    always_comb begin
        perm_ok = 1'b0;
        if (!req.is_d)
            perm_ok = req.pr ? entry_permis[PERM_UX] : entry_permis[PERM_SX];
        else if (req.store)
            perm_ok = req.pr ? entry_permis[PERM_UW] : entry_permis[PERM_SW];
        else
            perm_ok = req.pr ? entry_permis[PERM_UR] : entry_permis[PERM_SR];
    end

endmodule

// File: rtl/utlb_lookup_sequencer.sv
// Arbitrates IMMU/DMMU lookups onto one TLB read port and scans one entry per cycle.
// Optional last-hit start index per requester: define UTLB_LAST_HIT_CACHE_EN.
module utlb_lookup_sequencer
    import mmu_pkg::*;
#(
    parameter int unsigned NUM_ENTRIES = 16,
    parameter int unsigned IDX_W       = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      MSR_PR,
    input  logic [PID_W-1:0]          PID0,
    input  logic [PID_W-1:0]          PID1,
    input  logic [PID_W-1:0]          PID2,
    utlb_lookup_sequencer_if.slave    rif,
    input  logic                      TLB_Wr,
    output logic [IDX_W-1:0]          TLB_Rd_Idx,
    input  logic                      TLB_entry_V,
    input  logic                      TLB_entry_TS,
    input  logic [PID_W-1:0]          TLB_entry_TID,
    input  logic [EPN_W-1:0]          TLB_entry_EPN,
    input  logic [PERM_W-1:0]         TLB_entry_PERMIS,
    output logic                      Busy
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_ENTRIES - 1);

    state_t           state_q, state_nxt;
    req_t             req_q, req_nxt;
    logic [IDX_W-1:0] idx_q, idx_nxt;
    logic             rr_d_q, rr_d_nxt;
    logic             busy_q, busy_nxt;
    logic             i_ack_q, i_ack_nxt, i_hit_q, i_hit_nxt;
    logic             d_ack_q, d_ack_nxt, d_hit_q, d_hit_nxt;
    logic [IDX_W-1:0] i_idx_q, i_idx_nxt, d_idx_q, d_idx_nxt;
    logic [EXC_W-1:0] i_exc_q, i_exc_nxt, d_exc_q, d_exc_nxt;
    logic             grant_d;
    logic             match, perm_ok, last_c;

`ifdef UTLB_LAST_HIT_CACHE_EN
    logic [IDX_W-1:0] cnt_q, cnt_nxt;
    logic [IDX_W-1:0] i_cidx_q, i_cidx_nxt, d_cidx_q, d_cidx_nxt;
    logic             i_cvld_q, i_cvld_nxt, d_cvld_q, d_cvld_nxt;

    assign last_c = (cnt_q == LAST_IDX);
`else
    assign last_c = (idx_q == LAST_IDX);
`endif

    utlb_entry_check u_entry_check (
        .req          (req_q),
        .entry_v      (TLB_entry_V),
        .entry_ts     (TLB_entry_TS),
        .entry_tid    (TLB_entry_TID),
        .entry_epn    (TLB_entry_EPN),
        .entry_permis (TLB_entry_PERMIS),
        .match        (match),
        .perm_ok      (perm_ok)
    );

    // Next state, scan index and response registers
    always_comb begin
        state_nxt = state_q;
        req_nxt   = req_q;
        idx_nxt   = idx_q;
        rr_d_nxt  = rr_d_q;
        grant_d   = 1'b0;
        i_ack_nxt = 1'b0;
        i_hit_nxt = 1'b0;
        i_idx_nxt = '0;
        i_exc_nxt = EXC_NONE;
        d_ack_nxt = 1'b0;
        d_hit_nxt = 1'b0;
        d_idx_nxt = '0;
        d_exc_nxt = EXC_NONE;
`ifdef UTLB_LAST_HIT_CACHE_EN
        cnt_nxt    = cnt_q;
        i_cidx_nxt = i_cidx_q;
        i_cvld_nxt = i_cvld_q;
        d_cidx_nxt = d_cidx_q;
        d_cvld_nxt = d_cvld_q;
`endif
        unique case (state_q)
            ST_IDLE: begin
                if (rif.I_Req || rif.D_Req) begin
                    grant_d = rif.D_Req && (!rif.I_Req || rr_d_q);
                    if (rif.I_Req && rif.D_Req)
                        rr_d_nxt = !rr_d_q;
                    req_nxt.is_d  = grant_d;
                    req_nxt.store = grant_d && rif.D_Ins_Type;
                    req_nxt.pr    = MSR_PR;
                    req_nxt.as    = grant_d ? rif.D_AS : rif.I_AS;
                    req_nxt.epn   = grant_d ? rif.D_EA_EPN : rif.I_EA_EPN;
                    req_nxt.pid0  = PID0;
                    req_nxt.pid1  = PID1;
                    req_nxt.pid2  = PID2;
                    idx_nxt       = '0;
`ifdef UTLB_LAST_HIT_CACHE_EN
                    cnt_nxt = '0;
                    if (!TLB_Wr) begin
                        if (grant_d && d_cvld_q)
                            idx_nxt = d_cidx_q;
                        else if (!grant_d && i_cvld_q)
                            idx_nxt = i_cidx_q;
                    end
`endif
                    state_nxt = ST_SCAN;
                end
            end
            ST_SCAN: begin
                if (TLB_Wr) begin
                    idx_nxt = '0;
`ifdef UTLB_LAST_HIT_CACHE_EN
                    cnt_nxt = '0;
`endif
                end else if (match) begin
                    state_nxt = ST_DONE;
                    if (req_q.is_d) begin
                        d_ack_nxt = 1'b1;
                        d_hit_nxt = perm_ok;
                        d_idx_nxt = idx_q;
                        d_exc_nxt = perm_ok ? EXC_NONE : EXC_DSI;
                    end else begin
                        i_ack_nxt = 1'b1;
                        i_hit_nxt = perm_ok;
                        i_idx_nxt = idx_q;
                        i_exc_nxt = perm_ok ? EXC_NONE : EXC_ISI;
                    end
`ifdef UTLB_LAST_HIT_CACHE_EN
                    if (req_q.is_d) begin
                        d_cidx_nxt = idx_q;
                        d_cvld_nxt = 1'b1;
                    end else begin
                        i_cidx_nxt = idx_q;
                        i_cvld_nxt = 1'b1;
                    end
`endif
                end else if (last_c) begin
                    state_nxt = ST_DONE;
                    if (req_q.is_d) begin
                        d_ack_nxt = 1'b1;
                        d_exc_nxt = EXC_DTLB;
                    end else begin
                        i_ack_nxt = 1'b1;
                        i_exc_nxt = EXC_ITLB;
                    end
                end else begin
                    idx_nxt = idx_q + IDX_W'(1);
`ifdef UTLB_LAST_HIT_CACHE_EN
                    cnt_nxt = cnt_q + IDX_W'(1);
`endif
                end
            end
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
`ifdef UTLB_LAST_HIT_CACHE_EN
        if (TLB_Wr) begin
            i_cvld_nxt = 1'b0;
            d_cvld_nxt = 1'b0;
        end
`endif
        // Read index is only presented while scanning
        if (state_nxt != ST_SCAN)
            idx_nxt = '0;
        busy_nxt = (state_nxt == ST_SCAN);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            req_q   <= '0;
            idx_q   <= '0;
            rr_d_q  <= 1'b1;
            busy_q  <= 1'b0;
            i_ack_q <= 1'b0;
            i_hit_q <= 1'b0;
            i_idx_q <= '0;
            i_exc_q <= EXC_NONE;
            d_ack_q <= 1'b0;
            d_hit_q <= 1'b0;
            d_idx_q <= '0;
            d_exc_q <= EXC_NONE;
`ifdef UTLB_LAST_HIT_CACHE_EN
            cnt_q    <= '0;
            i_cidx_q <= '0;
            i_cvld_q <= 1'b0;
            d_cidx_q <= '0;
            d_cvld_q <= 1'b0;
`endif
        end else begin
            state_q <= state_nxt;
            req_q   <= req_nxt;
            idx_q   <= idx_nxt;
            rr_d_q  <= rr_d_nxt;
            busy_q  <= busy_nxt;
            i_ack_q <= i_ack_nxt;
            i_hit_q <= i_hit_nxt;
            i_idx_q <= i_idx_nxt;
            i_exc_q <= i_exc_nxt;
            d_ack_q <= d_ack_nxt;
            d_hit_q <= d_hit_nxt;
            d_idx_q <= d_idx_nxt;
            d_exc_q <= d_exc_nxt;
`ifdef UTLB_LAST_HIT_CACHE_EN
            cnt_q    <= cnt_nxt;
            i_cidx_q <= i_cidx_nxt;
            i_cvld_q <= i_cvld_nxt;
            d_cidx_q <= d_cidx_nxt;
            d_cvld_q <= d_cvld_nxt;
`endif
        end
    end

    assign TLB_Rd_Idx      = idx_q;
    assign Busy            = busy_q;
    assign rif.I_Ack       = i_ack_q;
    assign rif.I_Hit       = i_hit_q;
    assign rif.I_Idx       = i_idx_q;
    assign rif.I_Exception = i_exc_q;
    assign rif.D_Ack       = d_ack_q;
    assign rif.D_Hit       = d_hit_q;
    assign rif.D_Idx       = d_idx_q;
    assign rif.D_Exception = d_exc_q;

endmodule
